// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter that shares one APB master port
// among NUM_REQ local requesters. Latches the winning requester's command,
// runs the APB SETUP and ACCESS phases, and returns read data and error status
// with a one-cycle done pulse.
//
// Handshake: a requester holds req_valid_in[i] high until it sees
// req_done_out[i]. The done pulse is the only completion indication.
// req_rdata_out and req_error_out are valid with the pulse and hold until the
// next pulse. The requester must drop req_valid_in[i] before the clock edge
// that follows its done pulse, or it will be considered for a new transfer.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort ACCESS phases that
// wait TIMEOUT_CYCLE cycles without apb_ready_in. The abort completes the
// transfer with req_error_out=1 and req_rdata_out=0.
//
// arb_state is a debug copy of the one-hot FSM state (IDLE=001, SETUP=010,
// ACCESS=100).
module apb_master_arb #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLE  = 16
) (
    input  logic                               apb_clk_in,
    input  logic                               apb_rstn_in,
    input  logic [NUM_REQ-1:0]                 req_valid_in,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [NUM_REQ-1:0]                 req_write_in,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata_in,
    output logic [NUM_REQ-1:0]                 req_grant_out,
    output logic [NUM_REQ-1:0]                 req_done_out,
    output logic [APB_DATA_WIDTH-1:0]          req_rdata_out,
    output logic                               req_error_out,
    output logic                               apb_psel_out,
    output logic                               apb_penable_out,
    output logic [APB_ADDR_WIDTH-1:0]          apb_addr_out,
    output logic                               apb_write_out,
    output logic [APB_DATA_WIDTH-1:0]          apb_wdata_out,
    input  logic [APB_DATA_WIDTH-1:0]          apb_rdata_in,
    input  logic                               apb_ready_in,
    input  logic                               apb_slverr_in,
    output logic [2:0]                         arb_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time sanity checks on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("apb_master_arb: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLE < 1) begin : g_bad_timeout
        $error("apb_master_arb: TIMEOUT_CYCLE must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SETUP  = 3'b010,
        ST_ACCESS = 3'b100
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    assign arb_state = state;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLE);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;

    // Saturating next value of the ACCESS wait counter.
    always_comb begin
        wait_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
`endif

    // Round-robin pick: first valid requester searching upward from last_grant+1.
    always_comb begin
        int cand;
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!pick_found && req_valid_in[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Arbiter/sequencer FSM with registered APB and requester outputs.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state           <= ST_IDLE;
            last_grant      <= IDX_W'(NUM_REQ - 1);
            grant_idx       <= '0;
            req_grant_out   <= '0;
            req_done_out    <= '0;
            req_rdata_out   <= '0;
            req_error_out   <= 1'b0;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            apb_addr_out    <= '0;
            apb_write_out   <= 1'b0;
            apb_wdata_out   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            // The done pulse lasts exactly one cycle.
            req_done_out <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_idx       <= pick_idx;
                        req_grant_out   <= NUM_REQ'(1) << pick_idx;
                        apb_addr_out    <= req_addr_in[pick_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                        apb_write_out   <= req_write_in[pick_idx];
                        apb_wdata_out   <= req_wdata_in[pick_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                        apb_psel_out    <= 1'b1;
                        apb_penable_out <= 1'b0;
                        state           <= ST_SETUP;
                    end else begin
                        req_grant_out   <= '0;
                        apb_psel_out    <= 1'b0;
                        apb_penable_out <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    apb_penable_out <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_cnt        <= '0;
`endif
                    state           <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb_ready_in) begin
                        req_done_out    <= req_grant_out;
                        req_error_out   <= apb_slverr_in;
                        req_rdata_out   <= (!apb_write_out && !apb_slverr_in) ? apb_rdata_in : '0;
                        last_grant      <= grant_idx;
                        req_grant_out   <= '0;
                        apb_psel_out    <= 1'b0;
                        apb_penable_out <= 1'b0;
                        state           <= ST_IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (wait_inc == CNT_MAX) begin
                        // Slave never answered: complete with an error.
                        req_done_out    <= req_grant_out;
                        req_error_out   <= 1'b1;
                        req_rdata_out   <= '0;
                        last_grant      <= grant_idx;
                        req_grant_out   <= '0;
                        apb_psel_out    <= 1'b0;
                        apb_penable_out <= 1'b0;
                        wait_cnt        <= wait_inc;
                        state           <= ST_IDLE;
                    end else begin
                        wait_cnt        <= wait_inc;
                    end
`endif
                end
                default: begin
                    req_grant_out   <= '0;
                    apb_psel_out    <= 1'b0;
                    apb_penable_out <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed testbench for apb_master_arb (NUM_REQ=4, 32-bit address/data).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_apb_master_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_write;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_grant;
    logic [N-1:0]      req_done;
    logic [DW-1:0]     req_rdata;
    logic              req_error;
    logic              psel;
    logic              penable;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;
    logic [2:0]        arb_state;

    apb_master_arb #(
        .NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLE(16)
    ) dut (
        .apb_clk_in      (clk),
        .apb_rstn_in     (rst_n),
        .req_valid_in    (req_valid),
        .req_addr_in     (req_addr),
        .req_write_in    (req_write),
        .req_wdata_in    (req_wdata),
        .req_grant_out   (req_grant),
        .req_done_out    (req_done),
        .req_rdata_out   (req_rdata),
        .req_error_out   (req_error),
        .apb_psel_out    (psel),
        .apb_penable_out (penable),
        .apb_addr_out    (paddr),
        .apb_write_out   (pwrite),
        .apb_wdata_out   (pwdata),
        .apb_rdata_in    (prdata),
        .apb_ready_in    (pready),
        .apb_slverr_in   (pslverr),
        .arb_state       (arb_state)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_psel"},    32'(psel),      32'd0);
        check({tag, "_penable"}, 32'(penable),   32'd0);
        check({tag, "_grant"},   32'(req_grant), 32'd0);
        check({tag, "_done"},    32'(req_done),  32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #2;
        do_reset();

        // Reset state
        check_idle_outputs("rst");
        check("rst_rdata", req_rdata, 32'd0);
        check("rst_error", 32'(req_error), 32'd0);
        check("rst_addr",  paddr, 32'd0);
        check("rst_state", 32'(arb_state), 32'b001);

        // Single read from req 0, zero-wait
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        prdata = 32'hDEADBEEF;
        pready = 1'b1;
        tick();
        check("rd_psel",    32'(psel),      32'd1);
        check("rd_penable", 32'(penable),   32'd0);
        check("rd_grant",   32'(req_grant), 32'b0001);
        check("rd_addr",    paddr,          32'h10);
        check("rd_write",   32'(pwrite),    32'd0);
        tick();
        check("rd_penable2", 32'(penable),  32'd1);
        check("rd_psel2",    32'(psel),     32'd1);
        check("rd_done_early", 32'(req_done), 32'd0);
        tick();
        check("rd_done",  32'(req_done),  32'b0001);
        check("rd_rdata", req_rdata,      32'hDEADBEEF);
        check("rd_error", 32'(req_error), 32'd0);
        check("rd_psel_drop", 32'(psel),  32'd0);
        check("rd_grant_drop", 32'(req_grant), 32'd0);
        req_valid[0] = 1'b0;
        tick();
        check("rd_done_pulse", 32'(req_done), 32'd0);
        check("rd_rdata_hold", req_rdata, 32'hDEADBEEF);
        check("rd_idle_psel", 32'(psel), 32'd0);

        // Write from req 2 with three wait states
        set_req(2, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        pready = 1'b0;
        tick();
        check("wr_grant", 32'(req_grant), 32'b0100);
        check("wr_addr",  paddr,          32'h40);
        check("wr_wdata", pwdata,         32'h1234_5678);
        check("wr_write", 32'(pwrite),    32'd1);
        // Late changes to the requester's command are ignored.
        set_req(2, 1'b1, 1'b0, 32'h99, 32'hAAAA_5555);
        tick();
        check("wr_penable", 32'(penable), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_wait_addr",  paddr,            32'h40);
            check("wr_wait_wdata", pwdata,           32'h1234_5678);
            check("wr_wait_done",  32'(req_done),    32'd0);
            check("wr_wait_pen",   32'(penable),     32'd1);
        end
        pready = 1'b1;
        prdata = 32'hCAFE_F00D;
        tick();
        check("wr_done",  32'(req_done),  32'b0100);
        check("wr_rdata", req_rdata,      32'd0);
        check("wr_error", 32'(req_error), 32'd0);
        req_valid[2] = 1'b0;
        tick();
        check_idle_outputs("wr_after");

        // All four valid: grant order 0,1,2,3,0 from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'(32'h100 + i * 4), 32'h0);
        pready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            int exp_i;
            exp_i  = t % N;
            prdata = 32'(32'hA0 + t);
            tick();
            check("rr_grant", 32'(req_grant), 32'(1 << exp_i));
            check("rr_addr",  paddr,          32'(32'h100 + exp_i * 4));
            tick();
            check("rr_penable", 32'(penable), 32'd1);
            tick();
            check("rr_done",      32'(req_done), 32'(1 << exp_i));
            check("rr_rdata",     req_rdata,     32'(32'hA0 + t));
            check("rr_idle_psel", 32'(psel),     32'd0);
        end
        req_valid = '0;
        tick();
        check_idle_outputs("rr_after");

        // Read with slave error
        set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
        prdata  = 32'h0000_FFFF;
        pslverr = 1'b1;
        tick();
        check("err_grant", 32'(req_grant), 32'b0010);
        tick();
        tick();
        check("err_done",  32'(req_done),  32'b0010);
        check("err_error", 32'(req_error), 32'd1);
        check("err_rdata", req_rdata,      32'd0);
        req_valid[1] = 1'b0;
        pslverr = 1'b0;
        tick();
        check("err_error_hold", 32'(req_error), 32'd1);

        // Reset during ACCESS
        set_req(3, 1'b1, 1'b0, 32'h80, 32'h0);
        pready = 1'b0;
        prdata = 32'h5A5A_5A5A;
        tick();
        check("rst_mid_grant", 32'(req_grant), 32'b1000);
        tick();
        tick();
        check("rst_mid_access", 32'(arb_state), 32'b100);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid_error", 32'(req_error), 32'd0);
        check("rst_mid_rdata", req_rdata,      32'd0);
        pready = 1'b1;
        tick();
        check("rst_mid_nodone", 32'(req_done), 32'd0);
        rst_n = 1'b1;
        #1;
        tick();
        check("rearb_grant", 32'(req_grant), 32'b1000);
        check("rearb_addr",  paddr,          32'h80);
        tick();
        tick();
        check("rearb_done",  32'(req_done), 32'b1000);
        check("rearb_rdata", req_rdata,     32'h5A5A_5A5A);
        req_valid[3] = 1'b0;
        tick();

        // Long ACCESS wait without PREADY
        set_req(0, 1'b1, 1'b0, 32'hC0, 32'h0);
        pready = 1'b0;
        prdata = 32'h1111_2222;
        tick();
        check("to_grant", 32'(req_grant), 32'b0001);
        tick();
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_wait_done", 32'(req_done), 32'd0);
        end
        tick();
        check("to_done",  32'(req_done),  32'b0001);
        check("to_error", 32'(req_error), 32'd1);
        check("to_rdata", req_rdata,      32'd0);
        check("to_psel",  32'(psel),      32'd0);
        req_valid[0] = 1'b0;
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("wait_done", 32'(req_done), 32'd0);
            check("wait_psel", 32'(psel),     32'd1);
        end
        pready = 1'b1;
        tick();
        check("wait_final_done",  32'(req_done),  32'b0001);
        check("wait_final_rdata", req_rdata,      32'h1111_2222);
        check("wait_final_error", 32'(req_error), 32'd0);
        req_valid[0] = 1'b0;
        tick();
`endif
        check_idle_outputs("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
